// File: rtl/seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [2:0]            digit_idx_t;
  typedef logic [NUM_DIGITS-1:0] digit_mask_t;

  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] CA_OFF = 7'h7F;

  // Active-low anode pattern selecting a single digit.
  function automatic digit_mask_t digit_sel_n(input digit_idx_t idx);
    return ~(digit_mask_t'(1) << idx);
  endfunction

endpackage

// File: rtl/display_decoder.sv
// Hex nibble to seven-segment pattern, active-high: {a,b,c,d,e,f,g} in [7:1], dp in [0] (always 0).
module display_decoder (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (hex)
      4'h0: seg = 8'b1111110_0;
      4'h1: seg = 8'b0110000_0;
      4'h2: seg = 8'b1101101_0;
      4'h3: seg = 8'b1111001_0;
      4'h4: seg = 8'b0110011_0;
      4'h5: seg = 8'b1011011_0;
      4'h6: seg = 8'b1011111_0;
      4'h7: seg = 8'b1110000_0;
      4'h8: seg = 8'b1111111_0;
      4'h9: seg = 8'b1111011_0;
      4'hA: seg = 8'b1110111_0;
      4'hB: seg = 8'b0011111_0;
      4'hC: seg = 8'b1001110_0;
      4'hD: seg = 8'b0111101_0;
      4'hE: seg = 8'b1001111_0;
      4'hF: seg = 8'b1000111_0;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-boundary commit and per-slot blanking.
// Optional leading-zero blanking is built when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  en_mask,
  input  logic        load,
  output logic        pending,
  output logic        frame_start,
  output logic [7:0]  an,
  output logic [6:0]  ca,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [31:0]      pend_value_q, pend_value_d, show_value_q, show_value_d;
  digit_mask_t      pend_dp_q, pend_dp_d, show_dp_q, show_dp_d;
  digit_mask_t      pend_en_q, pend_en_d, show_en_q, show_en_d;
  logic             pending_q, pending_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       ca_q, ca_d;
  logic             dp_q, dp_d;

  logic        tick, wrap, slot_lit;
  logic [3:0]  nibble;
  logic [7:0]  seg;
  logic        dec_dp_unused;
  digit_mask_t lz_blank;

  assign nibble = show_value_q[4*idx_q +: 4];

  display_decoder u_dec (
    .hex (nibble),
    .seg (seg)
  );

  assign dec_dp_unused = seg[0];

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
`ifdef SEG_LZ_BLANK_EN
    begin
      logic nz_left;
      nz_left = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        nz_left     = nz_left | (show_value_q[4*i +: 4] != 4'h0);
        lz_blank[i] = ~nz_left;
      end
    end
`endif
  end

  always_comb begin
    tick = (cnt_q == CNT_LAST);
    wrap = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = tick ? idx_q + digit_idx_t'(1) : idx_q;

    show_value_d = show_value_q;
    show_dp_d    = show_dp_q;
    show_en_d    = show_en_q;
    if (wrap && pending_q) begin
      show_value_d = pend_value_q;
      show_dp_d    = pend_dp_q;
      show_en_d    = pend_en_q;
    end

    // A load on the wrap edge lands behind the commit, so it stays pending for a full frame.
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pending_d    = pending_q;
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_mask;
      pend_en_d    = en_mask;
      pending_d    = 1'b1;
    end else if (wrap) begin
      pending_d    = 1'b0;
    end

    slot_lit      = (cnt_q >= BLANK_END) && show_en_q[idx_q] && !lz_blank[idx_q];
    an_d          = slot_lit ? digit_sel_n(idx_q) : AN_OFF;
    ca_d          = ~seg[7:1];
    dp_d          = ~show_dp_q[idx_q];
    frame_start_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pending_q     <= 1'b0;
      show_value_q  <= '0;
      show_dp_q     <= '0;
      show_en_q     <= '0;
      frame_start_q <= 1'b0;
      an_q          <= AN_OFF;
      ca_q          <= CA_OFF;
      dp_q          <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pending_q     <= pending_d;
      show_value_q  <= show_value_d;
      show_dp_q     <= show_dp_d;
      show_en_q     <= show_en_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      ca_q          <= ca_d;
      dp_q          <= dp_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign an          = an_q;
  assign ca          = ca_q;
  assign dp          = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, checked every cycle against a
// cycle-count based reference model of the scan, commit and blanking rules.
module tb_seg_scan_ctrl;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  en_mask = '0;
  logic        load = 1'b0;
  logic        pending, frame_start, dp;
  logic [7:0]  an;
  logic [6:0]  ca;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .value       (value),
    .dp_mask     (dp_mask),
    .en_mask     (en_mask),
    .load        (load),
    .pending     (pending),
    .frame_start (frame_start),
    .an          (an),
    .ca          (ca),
    .dp          (dp)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  string phase  = "reset";

  // Reference model: slot position derived from cycles elapsed since reset.
  int          m_t = 0;
  bit          m_pending = 0;
  logic [31:0] m_pv = '0, m_sv = '0;
  logic [7:0]  m_pd = '0, m_pe = '0, m_sd = '0, m_se = '0;
  logic [7:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_dp, e_fs, e_pend;

  function automatic logic [6:0] glyph_n(input int h);
    case (h)
      0: return 7'h01;   1: return 7'h4F;   2: return 7'h12;   3: return 7'h06;
      4: return 7'h4C;   5: return 7'h24;   6: return 7'h20;   7: return 7'h0F;
      8: return 7'h00;   9: return 7'h04;  10: return 7'h08;  11: return 7'h60;
     12: return 7'h31;  13: return 7'h42;  14: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s at t=%0d: observed %h expected %h", phase, tag, m_t, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  cnt, idx;
    bit  wrap, lit;
    if (!n_rst) begin
      m_t = 0; m_pending = 0;
      m_sv = '0; m_sd = '0; m_se = '0;
      e_an = 8'hFF; e_ca = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      cnt  = m_t % RD;
      idx  = (m_t / RD) % 8;
      wrap = (m_t % FRAME) == FRAME - 1;
      lit  = (cnt >= BC) && m_se[idx];
`ifdef SEG_LZ_BLANK_EN
      if (idx > 0 && (m_sv >> (4 * idx)) == 0) lit = 0;
`endif
      e_an = lit ? (8'hFF ^ (8'd1 << idx)) : 8'hFF;
      e_ca = glyph_n(int'((m_sv >> (4 * idx)) & 32'hF));
      e_dp = ~m_sd[idx];
      e_fs = wrap;
      if (wrap && m_pending) begin
        m_sv = m_pv; m_sd = m_pd; m_se = m_pe;
      end
      if (load) begin
        m_pv = value; m_pd = dp_mask; m_pe = en_mask; m_pending = 1;
      end else if (wrap) begin
        m_pending = 0;
      end
      m_t++;
    end
    e_pend = m_pending;
  endtask

  task automatic step(input bit ld, input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    @(negedge clk);
    load = ld; value = v; dp_mask = d; en_mask = e;
    @(posedge clk);
    model_edge();
    #1;
    chk("an", an, e_an);
    chk("ca", {1'b0, ca}, {1'b0, e_ca});
    chk("dp", {7'b0, dp}, {7'b0, e_dp});
    chk("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
    chk("pending", {7'b0, pending}, {7'b0, e_pend});
  endtask

  // Idle cycles drive junk on the data inputs; it must be ignored without load.
  task automatic idle();
    step(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic idle_until_wrap();
    while (m_t % FRAME != FRAME - 1) idle();
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (3) idle();
    n_rst = 1'b1;
    phase = "dark_after_reset";
    repeat (FRAME + 10) idle();

    phase = "basic_scan";
    step(1'b1, 32'h8765_4321, 8'h01, 8'hFF);
    repeat (2 * FRAME + 10) idle();

    phase = "tear_free_overwrite";
    repeat (20) idle();
    step(1'b1, 32'hAAAA_1111, 8'hF0, 8'hFF);
    repeat (9) idle();
    step(1'b1, 32'hBBBB_2222, 8'h0F, 8'hFF);
    repeat (FRAME + 10) idle();

    phase = "load_on_wrap";
    repeat (5) idle();
    step(1'b1, 32'hCAFE_F00D, 8'h55, 8'hFF);
    idle_until_wrap();
    step(1'b1, 32'hDEAD_BEEF, 8'hAA, 8'hFF);
    repeat (FRAME + 10) idle();

    phase = "enable_mask";
    step(1'b1, 32'h1234_5678, 8'h00, 8'h0F);
    repeat (2 * FRAME + 5) idle();

    phase = "leading_zero_a0";
    step(1'b1, 32'h0000_00A0, 8'h00, 8'hFF);
    repeat (2 * FRAME + 5) idle();
    phase = "leading_zero_0";
    step(1'b1, 32'h0000_0000, 8'h00, 8'hFF);
    repeat (2 * FRAME + 5) idle();

    phase = "random";
    repeat (25) begin
      repeat ($urandom_range(0, 90)) idle();
      if ($urandom_range(0, 3) == 0) idle_until_wrap();
      step(1'b1, $urandom, 8'($urandom), 8'($urandom));
    end
    repeat (2 * FRAME) idle();

    phase = "reset_mid_frame";
    while (((m_t / RD) % 8) != 4) idle();
    step(1'b1, 32'h5A5A_5A5A, 8'hFF, 8'hFF);
    while (((m_t / RD) % 8) != 5) idle();
    n_rst = 1'b0;
    idle();
    chk("pending_cleared", {7'b0, pending}, 8'h00);
    n_rst = 1'b1;
    phase = "after_mid_reset";
    repeat (FRAME + 10) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the Nexys A7 eight-digit seven-segment display. It holds a 32-bit hex value plus per-digit decimal-point and enable masks, and steps through the digits at a programmable refresh rate. Each nibble goes through the existing `display_decoder` to get its segment pattern. The block drives the active-low anode, cathode and decimal-point pins, with an inter-digit blanking window to prevent ghosting. New values are committed only at frame boundaries, so the display never tears mid-scan.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000: clock cycles per digit slot (1 kHz/digit at 100 MHz). Must be ≥ 2.
- `BLANK_CYCLES`, default 1_000: cycles at the start of each slot with all anodes off. Must be < `REFRESH_DIV`.

Ports (clock and reset first):
- `clk`, input, 1: system clock.
- `n_rst`, input, 1: reset, synchronous, active-low.
- `value`, input, 32: hex value; nibble i maps to digit i (digit 0 is rightmost).
- `dp_mask`, input, 8: decimal-point enable per digit, active-high.
- `en_mask`, input, 8: digit enable, active-high.
- `load`, input, 1: single-cycle strobe that captures `value`, `dp_mask` and `en_mask` into the pending register.
- `pending`, output, 1: high while captured data awaits its frame-boundary commit.
- `frame_start`, output, 1: one-cycle pulse when the digit index wraps from 7 to 0.
- `an`, output, 8: anodes, active-low.
- `ca`, output, 7: cathodes CA–CG (`ca[6]` is CA), active-low.
- `dp`, output, 1: decimal point, active-low.

## Operation
- **Prescaler `cnt`:**
  - Counts 0 to `REFRESH_DIV-1` and then wraps.
  - `tick` is asserted when `cnt == REFRESH_DIV-1`.
- **Digit index `idx` (3-bit):**
  - Increments on `tick`.
  - Wraps from 7 to 0; this wrap is the frame boundary.
- **Registers:**
  - The pending register (`pend_*`) is written on `load`. `pending` is set to 1 and back-to-back loads overwrite it.
  - The shown register (`show_*`) takes the pending data at the frame boundary when `pending = 1`, and `pending` clears.
- **Load coinciding with the frame boundary:**
  - The prior pending contents commit to `show_*`.
  - The new data goes into `pend_*` and `pending` stays 1.
  - If `pending` was 0, nothing commits and the new data becomes pending.
- **Slot output** for the current `idx`:
  - Blanked (`an = 8'hFF`) when `cnt < BLANK_CYCLES` or `show_en[idx] = 0`.
  - Otherwise `an = ~(8'b1 << idx)`.
  - `ca` is the inverse of decoder bits [7:1] for `show_value[4*idx +: 4]`.
  - `dp = ~show_dp[idx]`.
  - `ca` and `dp` are still driven while blanked; they are harmless because no anode is active.
- **Decoder convention:** `display_decoder` output is active-high, with {a..g} in bits [7:1] and the decimal point in bit 0. Bit 0 is ignored; `dp` comes from the mask.

## Timing
- **Reset values:**
  - `an = 8'hFF`, `ca = 7'h7F`, `dp = 1`, `pending = 0`, `frame_start = 0`.
  - `cnt = 0`, `idx = 0`.
  - `show_value = 0`, `show_dp = 0`, `show_en = 0`.
  - The display is therefore dark after reset until the first commit.
- **Output latency:** `an`, `ca`, `dp` and `frame_start` are registered, one cycle after the `cnt`/`idx` state that produces them.
- **Load to visible:**
  - `load` is captured on the edge where it is high; `pending` is high the next cycle.
  - The data becomes visible at most 8·`REFRESH_DIV` + 1 cycles later.
- **`frame_start`:** high for exactly one cycle per frame, the cycle after the wrap edge. The commit occurs on that same wrap edge.
- **Reset mid-frame:** all state returns to reset values on the next edge with `n_rst = 0`, and any pending data is discarded.
- **Digit-rate arithmetic:** digit rate is `f_clk / REFRESH_DIV`. `cnt` width is `$clog2(REFRESH_DIV)`.

## Configuration
- **`SEG_LZ_BLANK_EN`** (leading-zero blanking):
  - **Defined:** digit i (i ≥ 1) is additionally blanked when every `show_value` nibble from 7 down to i is zero. Digit 0 is never blanked by this rule, so a value of 0 shows a single "0".
  - **Undefined:** all enabled digits are displayed, including leading zeros.
- `en_mask` applies in both builds.

## Structure
- **Package `seg_pkg`:**
  - `NUM_DIGITS = 8`.
  - `typedef logic [2:0] digit_idx_t`.
  - `typedef logic [NUM_DIGITS-1:0] digit_mask_t`.
  - Reset constants `AN_OFF = 8'hFF` and `CA_OFF = 7'h7F`.
- **Sub-module:** one instance of `display_decoder`, fed by the nibble mux. No other sub-modules.

## Test plan
All directed tests run with `REFRESH_DIV = 8` and `BLANK_CYCLES = 2`.
- **Reset:** hold `n_rst = 0` for 3 cycles, then release with no `load` → `an = FF`, `ca = 7F`, `dp = 1` for 64+ cycles; `frame_start` pulses every 64 cycles.
- **Basic scan:** load `value = 32'h8765_4321`, `en_mask = FF`, `dp_mask = 8'h01` → after the next frame start:
  - Slot 0 shows `an = FE` and `ca` = ~"1" (`7'b1001111`) with `dp = 0`.
  - Slot 7 shows `an = 7F` with ~"8" (`7'h00`).
  - The first 2 cycles of every slot show `an = FF`.
- **Tear-free commit:** load A mid-frame, then load B 10 cycles later → only B is committed at the boundary and `pending` drops there. Load B coinciding with the wrap → A commits and `pending` stays 1 until the following frame.
- **Enable mask:** `en_mask = 8'h0F` → `an` bits 7..4 remain 1 throughout the frame.
- **Leading-zero blanking (`SEG_LZ_BLANK_EN` defined):**
  - `value = 32'h0000_00A0` → digits 7..2 dark, digit 1 shows "A", digit 0 shows "0".
  - `value = 0` → only digit 0 lit.
- **Reset mid-frame:** assert `n_rst = 0` at slot 5 with `pending = 1` → the next cycle shows reset values and `pending = 0`.
